rf_write_buffer: RTL and testbench

//  Write-side front end of the register file (sync write, async read). Queues writeback

---
 rtl/rf_write_buffer.sv | 150 +++++++++++++++
 tb/tb_rf_write_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_buffer.sv
// ----------------------------------------------------------------------------
// rf_write_buffer
//
// Write-side front end of the register file. Writeback requests are queued in
// a small FIFO and drained one per granted cycle into the reg_file write port.
// Both operand read ports see the newest value. That value is forwarded from
// the youngest pending entry with a matching address. If no entry matches,
// the port passes the reg_file's asynchronous read data through unchanged.
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   n_rst        synchronous active-low reset
//   in_valid     writeback request valid
//   in_ready     buffer can accept a request (not full)
//   in_addr      destination register of the request
//   in_data      value to write
//   rf_grant     reg_file write port available this cycle
//   rf_we        write enable to reg_file
//   rf_w_addr    head entry address to reg_file
//   rf_w_data    head entry data to reg_file
//   r1_addr      operand 1 address (also drives reg_file.r1_addr)
//   r1_rf_data   reg_file read data for operand 1
//   r1_data      forwarded operand 1
//   r1_fwd       1 when r1_data came from the buffer
//   r2_*         same as r1_*, for operand 2
//   count        number of occupied entries
//   empty        count == 0
// ----------------------------------------------------------------------------
module rf_write_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     n_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_grant,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_w_addr,
    output logic [DATA_W-1:0]        rf_w_data,
    input  logic [ADDR_W-1:0]        r1_addr,
    input  logic [DATA_W-1:0]        r1_rf_data,
    output logic [DATA_W-1:0]        r1_data,
    output logic                     r1_fwd,
    input  logic [ADDR_W-1:0]        r2_addr,
    input  logic [DATA_W-1:0]        r2_rf_data,
    output logic [DATA_W-1:0]        r2_data,
    output logic                     r2_fwd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic full;
    logic push;
    logic pop;

    // Full blocks a push even when a pop happens in the same cycle. This keeps
    // in_ready independent of rf_grant.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign rf_we     = !empty && rf_grant;
    assign pop       = rf_we;
    assign count     = count_q;
    assign rf_w_addr = mem[rd_ptr].addr;
    assign rf_w_data = mem[rd_ptr].data;

    // Control state: pointers, occupancy and per-entry valid bits.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid   <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            // A push never targets the slot being popped. A pop requires a
            // non-empty buffer, and a push requires a buffer that is not full.
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage. A request presented during reset is discarded.
    // NOTE: the data array has no reset. The valid bits and count already mark
    // which slots are meaningful, so clearing the storage would only add
    // reset fan-out.
    always_ff @(posedge clock) begin
        if (n_rst && push) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data};
        end
    end

    // Forwarding. The scan walks from oldest to youngest, and each later
    // match overrides the earlier ones. The result is the same as taking the
    // first match from the youngest end. The head entry keeps forwarding on
    // its commit cycle, because the reg_file read still shows the old value
    // until the edge.
    // NOTE: each output gets its default before the loop. Without that, the
    // no-match path would infer a latch.
    always_comb begin
        r1_data = r1_rf_data;
        r1_fwd  = 1'b0;
        r2_data = r2_rf_data;
        r2_fwd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[rd_ptr + PTR_W'(i)]) begin
                if (mem[rd_ptr + PTR_W'(i)].addr == r1_addr) begin
                    r1_data = mem[rd_ptr + PTR_W'(i)].data;
                    r1_fwd  = 1'b1;
                end
                if (mem[rd_ptr + PTR_W'(i)].addr == r2_addr) begin
                    r2_data = mem[rd_ptr + PTR_W'(i)].data;
                    r2_fwd  = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_rf_write_buffer
//
// Self-checking bench for rf_write_buffer. A behavioural reg_file (sync write,
// async read) sits behind the buffer. A scoreboard queue holds every accepted
// request in arrival order. Entries are compared against the commit port as
// they drain. The same queue predicts occupancy, ready and forwarded data.
// ----------------------------------------------------------------------------
module tb_rf_write_buffer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clock = 1'b0;
    logic              n_rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              rf_grant = 1'b0;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [DATA_W-1:0] r1_rf_data;
    logic [DATA_W-1:0] r1_data;
    logic              r1_fwd;
    logic [ADDR_W-1:0] r2_addr = '0;
    logic [DATA_W-1:0] r2_rf_data;
    logic [DATA_W-1:0] r2_data;
    logic              r2_fwd;
    logic [2:0]        count;
    logic              empty;

    logic [DATA_W-1:0] rf_model [16] = '{default: '0};
    req_t              exp_q [$];
    int                n_checks = 0;
    int                n_pass   = 0;

    rf_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .rf_grant   (rf_grant),
        .rf_we      (rf_we),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data),
        .r1_addr    (r1_addr),
        .r1_rf_data (r1_rf_data),
        .r1_data    (r1_data),
        .r1_fwd     (r1_fwd),
        .r2_addr    (r2_addr),
        .r2_rf_data (r2_rf_data),
        .r2_data    (r2_data),
        .r2_fwd     (r2_fwd),
        .count      (count),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    // Behavioural reg_file: async read, write on the rising edge.
    assign r1_rf_data = rf_model[r1_addr];
    assign r2_rf_data = rf_model[r2_addr];
    always @(posedge clock) begin
        if (rf_we) rf_model[rf_w_addr] <= rf_w_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Scoreboard update at each edge. The model decides whether a pop and a
    // push happen, using its own occupancy and the driven inputs.
    always @(posedge clock) begin : scoreboard
        int sz;
        sz = exp_q.size();
        if (!n_rst) begin
            exp_q.delete();
        end else begin
            if (rf_grant && sz != 0) begin
                check("commit_we",   32'(rf_we),     32'(1));
                check("commit_addr", 32'(rf_w_addr), 32'(exp_q[0].addr));
                check("commit_data", 32'(rf_w_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            if (in_valid && sz < DEPTH) exp_q.push_back('{addr: in_addr, data: in_data});
        end
    end

    // Newest value for an address: the youngest pending entry, else reg_file.
    function automatic logic [DATA_W:0] model_read(input logic [ADDR_W-1:0] a);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].addr == a) return {1'b1, exp_q[i].data};
        end
        return {1'b0, rf_model[a]};
    endfunction

    task automatic check_state(input string tag);
        logic [DATA_W:0] f1;
        logic [DATA_W:0] f2;
        int sz;
        f1 = model_read(r1_addr);
        f2 = model_read(r2_addr);
        sz = exp_q.size();
        check({tag, "/count"},    32'(count),    32'(sz));
        check({tag, "/empty"},    32'(empty),    32'(sz == 0));
        check({tag, "/in_ready"}, 32'(in_ready), 32'(sz < DEPTH));
        check({tag, "/rf_we"},    32'(rf_we),    32'(rf_grant && sz != 0));
        check({tag, "/r1_fwd"},   32'(r1_fwd),   32'(f1[DATA_W]));
        check({tag, "/r1_data"},  32'(r1_data),  32'(f1[DATA_W-1:0]));
        check({tag, "/r2_fwd"},   32'(r2_fwd),   32'(f2[DATA_W]));
        check({tag, "/r2_data"},  32'(r2_data),  32'(f2[DATA_W-1:0]));
        if (sz != 0) begin
            check({tag, "/head_addr"}, 32'(rf_w_addr), 32'(exp_q[0].addr));
            check({tag, "/head_data"}, 32'(rf_w_data), 32'(exp_q[0].data));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        #1;
        check_state(tag);
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic drain(input string tag);
        drive(1'b0, '0, '0);
        rf_grant = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(tag);
        check({tag, "/drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset, held for two edges with a request presented.
        n_rst   = 1'b0;
        r1_addr = 4'd1;
        r2_addr = 4'd2;
        drive(1'b1, 4'd1, 16'hDEAD);
        repeat (2) @(posedge clock);
        #1;
        check_state("reset");
        check("reset/rf1_untouched", 32'(rf_model[1]), 32'(0));
        n_rst = 1'b1;
        drive(1'b0, '0, '0);
        rf_grant = 1'b1;
        #1;
        check("reset/we_after", 32'(rf_we), 32'(0));
        check("reset/empty_after", 32'(empty), 32'(1));

        // Single write with an immediate grant.
        r1_addr = 4'd8;
        drive(1'b1, 4'd8, 16'h8000);
        step("t2_push");
        check("t2/r1_fwd", 32'(r1_fwd), 32'(1));
        check("t2/r1_data", 32'(r1_data), 32'h8000);
        check("t2/rf_we", 32'(rf_we), 32'(1));
        drive(1'b0, '0, '0);
        step("t2_commit");
        check("t2/empty", 32'(empty), 32'(1));
        check("t2/r1_fwd_after", 32'(r1_fwd), 32'(0));
        check("t2/r1_data_after", 32'(r1_data), 32'h8000);

        // Youngest match wins.
        rf_grant = 1'b0;
        r1_addr  = 4'd3;
        r2_addr  = 4'd5;
        drive(1'b1, 4'd3, 16'h1111); step("t3_a");
        drive(1'b1, 4'd3, 16'h2222); step("t3_b");
        drive(1'b1, 4'd5, 16'hAAAA); step("t3_c");
        drive(1'b0, '0, '0);
        #1;
        check("t3/r1_data", 32'(r1_data), 32'h2222);
        check("t3/r2_data", 32'(r2_data), 32'hAAAA);
        check("t3/count", 32'(count), 32'(3));
        check("t3/rf_we", 32'(rf_we), 32'(0));
        drain("t3_drain");
        check("t3/rf3", 32'(rf_model[3]), 32'h2222);

        // Full buffer and backpressure.
        rf_grant = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'(10 + i), 16'(16'h4000 + i));
            step("t4_fill");
        end
        drive(1'b1, 4'd14, 16'h4004);
        step("t4_hold");
        check("t4/count_full", 32'(count), 32'(4));
        check("t4/ready_full", 32'(in_ready), 32'(0));
        rf_grant = 1'b1;
        #1;
        check("t4/ready_pop_cycle", 32'(in_ready), 32'(0));
        step("t4_pop");
        check("t4/ready_after_pop", 32'(in_ready), 32'(1));
        step("t4_accept");
        drain("t4_drain");
        for (int i = 0; i <= DEPTH; i++) begin
            check("t4/rf_content", 32'(rf_model[10 + i]), 32'(16'h4000 + i));
        end

        // Wrap with concurrent push and pop.
        rf_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i), 16'(16'h0100 + i));
            step("t5_stream");
            check("t5/count", 32'(count), 32'(1));
        end
        drive(1'b0, '0, '0);
        step("t5_tail");
        for (int i = 0; i < 10; i++) begin
            check("t5/rf_content", 32'(rf_model[i]), 32'(16'h0100 + i));
        end

        // Reset with entries pending.
        rf_grant = 1'b0;
        r1_addr  = 4'd1;
        r2_addr  = 4'd2;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'(i), 16'(16'h6660 + i));
            step("t6_fill");
        end
        drive(1'b0, '0, '0);
        #1;
        check("t6/fwd_before", 32'(r1_fwd), 32'(1));
        n_rst = 1'b0;
        step("t6_reset");
        check("t6/count", 32'(count), 32'(0));
        check("t6/r1_fwd", 32'(r1_fwd), 32'(0));
        n_rst    = 1'b1;
        rf_grant = 1'b1;
        step("t6_post1");
        step("t6_post2");
        for (int i = 1; i <= 3; i++) begin
            check("t6/rf_kept", 32'(rf_model[i]), 32'(16'h0100 + i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
